// File: rtl/node_mem_pkg.sv
// Shared definitions for the 2048-byte node memory and its scan initiator.
// Address map, word geometry and the qvalue_scan FSM state encoding.
package node_mem_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int MEM_DEPTH  = 2048;

    // Entries per neighbor table; the scan index is sized for this.
    localparam int NEI_TABLE_ENTRIES = 64;

    localparam logic [15:0] ADDR_FLAGS        = 16'h0000;
    localparam logic [15:0] ADDR_KNOWN_SINKS  = 16'h0002;
    localparam logic [15:0] ADDR_NEI_ID       = 16'h0048;
    localparam logic [15:0] ADDR_CLUSTER_ID   = 16'h00C8;
    localparam logic [15:0] ADDR_BATTERY_STAT = 16'h0148;
    localparam logic [15:0] ADDR_QVALUE       = 16'h01C8;
    localparam logic [15:0] ADDR_SINK_IDS     = 16'h0248;
    localparam logic [15:0] ADDR_BETTER_NEI   = 16'h0668;
    localparam logic [15:0] ADDR_NEI_COUNT    = 16'h068A;
    localparam logic [15:0] ADDR_BETTER_CNT   = 16'h068C;
    localparam logic [15:0] ADDR_RNG_SEED     = 16'h068E;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CNT,
        S_RD_Q,
        S_RD_ID,
        S_WB_ID,
        S_WB_CNT,
        S_DONE
    } qscan_state_e;

    // Byte address of 16-bit entry idx in a table starting at base.
    function automatic logic [15:0] tbl_addr(
        input logic [15:0] base,
        input logic [5:0]  idx
    );
        return base + {9'd0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/qvalue_scan.sv
// qvalue_scan: reads neighborCount, finds the max qValue entry, reads its ID.
// Ports: clock/nrst, start, busy/done/empty, best_idx/best_q/best_id,
// memory master mem_addr/mem_wr_en/mem_wdata, mem_rdata (combinational).
// Option QSCAN_WRITEBACK_EN: write betterNeighbors[0] and its count.
module qvalue_scan
    import node_mem_pkg::*;
#(
    parameter logic [15:0] NEI_COUNT_ADDR  = ADDR_NEI_COUNT,
    parameter logic [15:0] QVALUE_BASE     = ADDR_QVALUE,
    parameter logic [15:0] NEI_ID_BASE     = ADDR_NEI_ID,
    parameter int          MAX_NEIGHBORS   = NEI_TABLE_ENTRIES,
    parameter logic [15:0] BETTER_NEI_BASE = ADDR_BETTER_NEI,
    parameter logic [15:0] BETTER_CNT_ADDR = ADDR_BETTER_CNT
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        empty,
    output logic [5:0]  best_idx,
    output logic [15:0] best_q,
    output logic [15:0] best_id,
    output logic [15:0] mem_addr,
    output logic        mem_wr_en,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    qscan_state_e r_state;
    qscan_state_e w_state_nxt;

    logic [6:0]  r_cnt;
    logic [5:0]  r_idx;
    logic [5:0]  r_best_idx;
    logic [15:0] r_best_q;
    logic [15:0] r_best_id;
    logic        r_empty;

    logic [6:0]  w_cnt_sat;
    logic        w_last;
    logic [15:0] w_addr;

    // Count is capped at table capacity so the walk never leaves the table.
    assign w_cnt_sat = (mem_rdata > 16'(MAX_NEIGHBORS)) ?
                       7'(MAX_NEIGHBORS) : mem_rdata[6:0];

    assign w_last = ({1'b0, r_idx} == (r_cnt - 7'd1));

`ifdef QSCAN_WRITEBACK_EN
    logic        w_wr;
    logic [15:0] w_wdata;
`endif

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr      = 16'h0000;
`ifdef QSCAN_WRITEBACK_EN
        w_wr        = 1'b0;
        w_wdata     = 16'h0000;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RD_CNT;
                end
            end
            S_RD_CNT: begin
                w_addr = NEI_COUNT_ADDR;
                if (w_cnt_sat == 7'd0) begin
`ifdef QSCAN_WRITEBACK_EN
                    w_state_nxt = S_WB_CNT;
`else
                    w_state_nxt = S_DONE;
`endif
                end else begin
                    w_state_nxt = S_RD_Q;
                end
            end
            S_RD_Q: begin
                w_addr = tbl_addr(QVALUE_BASE, r_idx);
                if (w_last) begin
                    w_state_nxt = S_RD_ID;
                end
            end
            S_RD_ID: begin
                w_addr = tbl_addr(NEI_ID_BASE, r_best_idx);
`ifdef QSCAN_WRITEBACK_EN
                w_state_nxt = S_WB_ID;
`else
                w_state_nxt = S_DONE;
`endif
            end
`ifdef QSCAN_WRITEBACK_EN
            S_WB_ID: begin
                w_addr      = BETTER_NEI_BASE;
                w_wr        = 1'b1;
                w_wdata     = r_best_id;
                w_state_nxt = S_WB_CNT;
            end
            S_WB_CNT: begin
                // An empty scan records zero better neighbors.
                w_addr      = BETTER_CNT_ADDR;
                w_wr        = 1'b1;
                w_wdata     = {15'd0, ~r_empty};
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_cnt      <= 7'd0;
            r_idx      <= 6'd0;
            r_best_idx <= 6'd0;
            r_best_q   <= 16'h0000;
            r_best_id  <= 16'h0000;
            r_empty    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx      <= 6'd0;
                        r_best_idx <= 6'd0;
                        r_best_q   <= 16'h0000;
                        r_best_id  <= 16'h0000;
                        r_empty    <= 1'b0;
                    end
                end
                S_RD_CNT: begin
                    r_cnt <= w_cnt_sat;
                    r_idx <= 6'd0;
                    if (w_cnt_sat == 7'd0) begin
                        r_empty <= 1'b1;
                    end
                end
                S_RD_Q: begin
                    // Strict compare: ties keep the lowest index.
                    if ((r_idx == 6'd0) || (mem_rdata > r_best_q)) begin
                        r_best_q   <= mem_rdata;
                        r_best_idx <= r_idx;
                    end
                    if (!w_last) begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                S_RD_ID: begin
                    r_best_id <= mem_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign empty    = r_empty;
    assign best_idx = r_best_idx;
    assign best_q   = r_best_q;
    assign best_id  = r_best_id;
    assign mem_addr = w_addr;

`ifdef QSCAN_WRITEBACK_EN
    assign mem_wr_en = w_wr;
    assign mem_wdata = w_wdata;
`else
    assign mem_wr_en = 1'b0;
    assign mem_wdata = 16'h0000;
`endif

endmodule

// File: tb/tb_qvalue_scan.sv
// Bench for qvalue_scan with a behavioural big-endian node memory.
// Directed scans; a monitor pops expected results whenever done is seen.
`timescale 1ns/1ps
module tb_qvalue_scan;

    logic        clock;
    logic        nrst;
    logic        start;
    logic        busy;
    logic        done;
    logic        empty;
    logic [5:0]  best_idx;
    logic [15:0] best_q;
    logic [15:0] best_id;
    logic [15:0] mem_addr;
    logic        mem_wr_en;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    qvalue_scan dut (
        .clock     (clock),
        .nrst      (nrst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .empty     (empty),
        .best_idx  (best_idx),
        .best_q    (best_q),
        .best_id   (best_id),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    localparam logic [15:0] A_CNT = 16'h068A;
    localparam logic [15:0] A_Q   = 16'h01C8;
    localparam logic [15:0] A_ID  = 16'h0048;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Node memory: combinational read, posedge write, host port for preload.
    logic [7:0]  mem [0:2047];
    logic        h_we;
    logic [15:0] h_addr;
    logic [15:0] h_data;
    logic [10:0] ra;

    always_comb begin
        ra        = mem_addr[10:0];
        mem_rdata = {mem[ra], mem[ra + 11'd1]};
    end

    always @(posedge clock) begin
        if (mem_wr_en) begin
            mem[mem_addr[10:0]]         <= mem_wdata[15:8];
            mem[mem_addr[10:0] + 11'd1] <= mem_wdata[7:0];
        end else if (h_we) begin
            mem[h_addr[10:0]]         <= h_data[15:8];
            mem[h_addr[10:0] + 11'd1] <= h_data[7:0];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  idx;
        logic [15:0] q;
        logic [15:0] id;
        logic        emp;
        int          lat;
        longint      t0;
    } exp_t;

    exp_t sb[$];

    function automatic int lat_of(input int cnt);
`ifdef QSCAN_WRITEBACK_EN
        return (cnt == 0) ? 3 : cnt + 5;
`else
        return (cnt == 0) ? 2 : cnt + 3;
`endif
    endfunction

    // Bus observation flags, cleared per test.
    logic        wr_seen;
    logic        q_seen;
    logic [15:0] q_max;

    always @(negedge clock) begin
        if (nrst && busy) begin
            if (mem_wr_en) wr_seen = 1'b1;
            if (mem_addr >= A_Q && mem_addr < 16'h0248) begin
                q_seen = 1'b1;
                if (mem_addr > q_max) q_max = mem_addr;
            end
        end
    end

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        int   lat;
        if (nrst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e   = sb.pop_front();
                lat = int'(($time - e.t0 - 5) / 10) + 1;
                chk("best_idx", best_idx, e.idx);
                chk("best_q", best_q, e.q);
                chk("best_id", best_id, e.id);
                chk("empty", empty, e.emp);
                chk("latency", lat, e.lat);
            end
        end
    end

    task automatic wr16(input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        h_addr = a;
        h_data = d;
        h_we   = 1'b1;
        @(posedge clock);
        #1 h_we = 1'b0;
    endtask

    task automatic clr_flags();
        wr_seen = 1'b0;
        q_seen  = 1'b0;
        q_max   = 16'h0000;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic run_scan(input int cnt, input logic [5:0] idx,
                            input logic [15:0] q, input logic [15:0] id,
                            input logic emp);
        exp_t e;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        e.idx = idx; e.q = q; e.id = id; e.emp = emp;
        e.lat = lat_of(cnt);
        e.t0  = $time;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
        drain();
    endtask

    task automatic load_case1();
        wr16(A_CNT, 16'd3);
        wr16(A_Q + 16'd0, 16'd5);
        wr16(A_Q + 16'd2, 16'd9);
        wr16(A_Q + 16'd4, 16'd7);
        wr16(A_ID + 16'd0, 16'd30);
        wr16(A_ID + 16'd2, 16'd31);
        wr16(A_ID + 16'd4, 16'd32);
    endtask

    initial begin
        exp_t e;
        start = 1'b0;
        h_we  = 1'b0;
        h_addr = '0;
        h_data = '0;
        nrst  = 1'b1;
        clr_flags();
        #3 nrst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_empty", empty, 0);
        chk("rst_best_q", best_q, 0);
        chk("rst_best_id", best_id, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        @(negedge clock);
        nrst = 1'b1;

        // Case 1: {5,9,7}
        load_case1();
        clr_flags();
        run_scan(3, 6'd1, 16'd9, 16'd31, 1'b0);
`ifdef QSCAN_WRITEBACK_EN
        chk("wb_id_hi", mem[16'h668], 8'h00);
        chk("wb_id_lo", mem[16'h669], 8'h1F);
        chk("wb_cnt_hi", mem[16'h68C], 8'h00);
        chk("wb_cnt_lo", mem[16'h68D], 8'h01);
`else
        chk("no_write_c1", wr_seen, 0);
`endif

        // Empty table
        wr16(A_CNT, 16'd0);
        clr_flags();
        run_scan(0, 6'd0, 16'd0, 16'd0, 1'b1);
        chk("empty_no_q_addr", q_seen, 0);

        // Ties, then 16'hFFFF wins
        wr16(A_CNT, 16'd4);
        wr16(A_Q + 16'd0, 16'd8);
        wr16(A_Q + 16'd2, 16'd8);
        wr16(A_Q + 16'd4, 16'd3);
        wr16(A_Q + 16'd6, 16'd8);
        wr16(A_ID + 16'd0, 16'd50);
        wr16(A_ID + 16'd2, 16'd51);
        wr16(A_ID + 16'd4, 16'd52);
        wr16(A_ID + 16'd6, 16'd53);
        run_scan(4, 6'd0, 16'd8, 16'd50, 1'b0);
        wr16(A_Q + 16'd4, 16'hFFFF);
        run_scan(4, 6'd2, 16'hFFFF, 16'd52, 1'b0);

        // Saturated count over a full table
        for (int i = 0; i < 64; i++) begin
            wr16(A_Q + 16'(2 * i), (i == 40) ? 16'd1000 : 16'(3 * i + 1));
            wr16(A_ID + 16'(2 * i), 16'(100 + i));
        end
        wr16(A_CNT, 16'd100);
        clr_flags();
        run_scan(64, 6'd40, 16'd1000, 16'd140, 1'b0);
        chk("last_q_addr", q_max, 16'h0246);

        // Abort mid-scan with reset, then rescan
        wr16(A_CNT, 16'd10);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1 chk("busy_mid_scan", busy, 1);
        #1 nrst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_best_q", best_q, 0);
        chk("abort_best_idx", best_idx, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_wr_en", mem_wr_en, 0);
        @(negedge clock);
        nrst = 1'b1;
        run_scan(10, 6'd9, 16'd28, 16'd109, 1'b0);

        // start held high: back-to-back scans
        load_case1();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        e.idx = 6'd1; e.q = 16'd9; e.id = 16'd31; e.emp = 1'b0;
        e.lat = lat_of(3);
        e.t0  = $time;
        sb.push_back(e);
        e.t0  = $time + longint'((lat_of(3) + 1) * 10);
        sb.push_back(e);
        repeat (lat_of(3) + 1) @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        drain();
`ifndef QSCAN_WRITEBACK_EN
        chk("no_write_total", wr_seen, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
